alu_op_scheduler: RTL and testbench
===================================

# alu_op_scheduler

Sequencer and arbiter that shares the single combinational ALU (8-way, `SEL`-selected result mux, signed N-bit operands, signed N+2-bit result) between two requesters, A and B. It accepts one operation at a time through a valid/ready handshake and arbitrates round-robin. It drives the ALU's operand and select inputs from registers, captures the ALU result into a register, and returns it with a requester ID over a result handshake. It sits between the operand sources and the ALU and is the only block that drives the ALU.

## Interface
- `N`, 4, ALU operand width; the result is N+2 bits signed.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `a_valid`  in  1  requester A has an operation.
- `a_ready`  out  1  A's operation is accepted this cycle.
- `a_op`  in  3  ALU select code for A.
- `a_x`, `a_y`  in  N  signed operands for A.
- `b_valid`, `b_ready`, `b_op`, `b_x`, `b_y`: same as A, for requester B.
- `alu_sel`  out  3  to ALU `SEL`.
- `alu_a`, `alu_b`  out  N  signed operands to ALU.
- `alu_res`  in  N+2  signed ALU result (combinational from `alu_sel`/`alu_a`/`alu_b`).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  N+2  signed captured result.
- `res_id`  out  1  owner of result: 0 = A, 1 = B.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  16  count of completed result handshakes; wraps.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - If neither `a_valid` nor `b_valid` is high, stay in IDLE.
  - If exactly one is high, grant that requester.
  - If both are high, grant the requester not granted last. A `last_id` register holds the last grant and resets to 1, so A wins the first tie.
  - The granted requester's ready is high combinationally in that cycle; the other ready is low. Ready is never high outside IDLE.
  - On grant, register op/x/y into `alu_sel`/`alu_a`/`alu_b`, register the ID into `res_id` and `last_id`, then go to EXEC.
- **EXEC**
  - One settle cycle for the ALU.
  - At the end of EXEC, capture `alu_res` into `res_data`, set `res_valid`=1, go to DONE.
- **DONE**
  - Hold `res_valid`, `res_data`, `res_id`, `alu_*` stable until `res_ready`=1.
  - On `res_valid && res_ready`: clear `res_valid`, increment `ops_done` (0xFFFF wraps to 0x0000), go to IDLE.
  - No new request is accepted in the handshake cycle.
- `alu_a`/`alu_b`/`alu_sel` change only on a grant.
- Width rule: `res_data` is `alu_res` verbatim. No re-extension or truncation; the sign is preserved.
- Requester inputs are ignored outside the grant cycle. A requester may change its op/x/y or drop valid while it is not ready.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE; `alu_sel`=0, `alu_a`=0, `alu_b`=0.
  - `res_valid`=0, `res_data`=0, `res_id`=0, `last_id`=1, `ops_done`=0.
  - `busy`=0; `a_ready`=`b_ready`=0 while `rst_n`=0.
- Latency:
  - Grant in cycle t.
  - `alu_*` valid from t+1 (EXEC).
  - `res_valid` high from t+2.
  - Minimum 3 cycles per operation when `res_ready` is held high.
- `busy` is high from t+1 until the cycle after the result handshake.
- A reset asserted mid-EXEC or mid-DONE aborts the operation: no result is emitted and `ops_done` is not incremented.
- A request held across the result handshake is accepted in the next IDLE cycle.

## Test plan
Bench ALU stub: `alu_res` = sign-extended (`alu_a` + `alu_b`), N=4.

1. Reset, then `a_valid`=1, `a_op`=3'b001, `a_x`=3, `a_y`=2, `res_ready`=1 -> `a_ready`=1 in cycle 0; `alu_sel`=1, `alu_a`=3, `alu_b`=2 in cycle 1; `res_valid`=1, `res_data`=5, `res_id`=0 in cycle 2; `ops_done`=1.
2. Both requesters valid continuously: A (x=-8, y=-8), B (x=7, y=7) -> grants alternate A, B, A, B; results -16 (id 0), 14 (id 1), repeating; `b_ready` is never high in the same cycle as `a_ready`.
3. Backpressure: `res_ready`=0 for 5 cycles after `res_valid` -> `res_data`, `res_id`, `alu_*` stay constant; `a_ready`=0 throughout; the handshake occurs on the cycle `res_ready` rises; `ops_done` increments once.
4. Reset mid-operation: deassert `rst_n` during EXEC -> all outputs take reset values immediately; after release, the next A-vs-B tie goes to A.
5. Counter wrap: preload 65535 completed operations (or force) -> the next handshake makes `ops_done`=0.
6. Valid dropped before grant: B pulses valid for one cycle while in EXEC -> no B grant; B's ready stays 0; no spurious result.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//
// Shares one combinational ALU between two requesters (A and B). One
// operation is in flight at a time. Requests are arbitrated round-robin,
// the operands and select code are registered onto the ALU inputs, the ALU
// result is captured one cycle later and returned with the owner's ID.
//
// Handshake semantics (all three channels):
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. A producer may raise, change or drop valid/payload freely while
//   ready is low; nothing is consumed until the transfer edge. a_ready and
//   b_ready are combinational and only ever high in IDLE (never both).
//   res_valid/res_data/res_id hold steady until res_ready is seen.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   a_valid/a_ready/a_op/a_x/a_y   requester A operation channel
//   b_valid/b_ready/b_op/b_x/b_y   requester B operation channel
//   alu_sel, alu_a, alu_b   registered ALU select and operands
//   alu_res                 combinational ALU result (N+2 bits signed)
//   res_valid/res_ready/res_data/res_id   result channel (id 0 = A, 1 = B)
//   busy                    high whenever the FSM is not IDLE
//   ops_done                wrapping count of completed result transfers
//   fsm_state               current FSM state (IDLE=0, EXEC=1, DONE=2)

module alu_op_scheduler #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_op,
  input  logic signed [N-1:0] a_x,
  input  logic signed [N-1:0] a_y,

  input  logic                b_valid,
  output logic                b_ready,
  input  logic [2:0]          b_op,
  input  logic signed [N-1:0] b_x,
  input  logic signed [N-1:0] b_y,

  output logic [2:0]          alu_sel,
  output logic signed [N-1:0] alu_a,
  output logic signed [N-1:0] alu_b,
  input  logic signed [N+1:0] alu_res,

  output logic                res_valid,
  input  logic                res_ready,
  output logic signed [N+1:0] res_data,
  output logic                res_id,

  output logic                busy,
  output logic [15:0]         ops_done,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   last_id;   // ID of the most recent grant; 1 after reset so A wins the first tie
  logic   grant_a;
  logic   grant_b;

  // Round-robin grant. A lone requester always wins; on a tie the requester
  // that was not granted last wins. Gated by rst_n so neither ready can be
  // seen high while the block is held in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (a_valid && (!b_valid || last_id)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      last_id   <= 1'b1;
      busy      <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // ALU inputs are loaded only here, so they stay frozen through
          // EXEC and DONE while the result is pending.
          if (grant_a) begin
            alu_sel <= a_op;
            alu_a   <= a_x;
            alu_b   <= a_y;
            res_id  <= 1'b0;
            last_id <= 1'b0;
            busy    <= 1'b1;
            state   <= EXEC;
          end else if (grant_b) begin
            alu_sel <= b_op;
            alu_a   <= b_x;
            alu_b   <= b_y;
            res_id  <= 1'b1;
            last_id <= 1'b1;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end

        EXEC: begin
          // The ALU has had a full cycle to settle on the registered inputs;
          // its result is taken verbatim, already N+2 bits signed.
          res_data  <= alu_res;
          res_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + 16'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                a_valid, b_valid;
  logic                a_ready, b_ready;
  logic [2:0]          a_op, b_op;
  logic signed [N-1:0] a_x, a_y, b_x, b_y;
  logic [2:0]          alu_sel;
  logic signed [N-1:0] alu_a, alu_b;
  logic signed [N+1:0] alu_res;
  logic                res_valid, res_ready;
  logic signed [N+1:0] res_data;
  logic                res_id;
  logic                busy;
  logic [15:0]         ops_done;
  logic [1:0]          fsm_state;

  // ALU stub: sign-extended sum of the operands.
  function automatic logic signed [N+1:0] stub(input logic signed [N-1:0] x,
                                               input logic signed [N-1:0] y);
    logic signed [N:0] s;
    s = {x[N-1], x} + {y[N-1], y};
    return {s[N], s};
  endfunction

  assign alu_res = stub(alu_a, alu_b);

  alu_op_scheduler #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .ops_done(ops_done), .fsm_state(fsm_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Entry = {id, expected result}.
  logic [N+2:0]        exp_q[$];
  int                  m_phase = 0;   // 0 idle, 1 exec, 2 done
  logic                m_last  = 1'b1;
  logic [2:0]          m_sel   = '0;
  logic signed [N-1:0] m_x     = '0;
  logic signed [N-1:0] m_y     = '0;
  logic [15:0]         m_ops   = '0;
  bit                  exp_a, exp_b;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_sel   = '0;
      m_x     = '0;
      m_y     = '0;
      m_ops   = '0;
      exp_q.delete();
    end else begin
      exp_a = (m_phase == 0) && a_valid && (!b_valid || m_last);
      exp_b = (m_phase == 0) && b_valid && (!a_valid || !m_last);
      chk("a_ready", a_ready, exp_a);
      chk("b_ready", b_ready, exp_b);
      chk("busy", busy, m_phase != 0);
      chk("res_valid", res_valid, m_phase == 2);
      chk("fsm_state", fsm_state, m_phase);
      chk("ops_done", ops_done, m_ops);
      chk("alu_sel", alu_sel, m_sel);
      chk("alu_a", alu_a, m_x);
      chk("alu_b", alu_b, m_y);
      if (m_phase == 2) begin
        if (exp_q.size() > 0) begin
          chk("res_data", res_data, $signed(exp_q[0][N+1:0]));
          chk("res_id", res_id, exp_q[0][N+2]);
        end else begin
          chk("result with empty queue", 1, 0);
        end
      end
      // advance the model across the coming rising edge
      case (m_phase)
        0: begin
          if (exp_a) begin
            exp_q.push_back({1'b0, stub(a_x, a_y)});
            m_sel = a_op; m_x = a_x; m_y = a_y; m_last = 1'b0; m_phase = 1;
          end else if (exp_b) begin
            exp_q.push_back({1'b1, stub(b_x, b_y)});
            m_sel = b_op; m_x = b_x; m_y = b_y; m_last = 1'b1; m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (res_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_ops   = m_ops + 16'd1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit av; int aop; int ax; int ay;
    bit bv; int bop; int bx; int by;
    int exp_id; int exp_res;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic drive_a(input bit v, input int op, input int x, input int y);
    a_valid = v; a_op = 3'(op); a_x = N'(x); a_y = N'(y);
  endtask

  task automatic drive_b(input bit v, input int op, input int x, input int y);
    b_valid = v; b_op = 3'(op); b_x = N'(x); b_y = N'(y);
  endtask

  // Called at negedge+2; returns at negedge+2 of the grant cycle.
  task automatic wait_grant();
    int n = 0;
    while (!(a_ready || b_ready) && n < 10) begin
      @(negedge clk); #2; n++;
    end
    if (!(a_ready || b_ready)) chk("grant timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #2;
    while ((busy || res_valid) && n < 20) begin
      @(negedge clk); #2; n++;
    end
    if (busy || res_valid) chk("idle timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n = 0;
    @(negedge clk);
    res_ready = 1'b1;
    drive_a(v.av, v.aop, v.ax, v.ay);
    drive_b(v.bv, v.bop, v.bx, v.by);
    #2;
    wait_grant();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #2;
    while (!res_valid && n < 10) begin
      @(negedge clk); #2; n++;
    end
    if (!res_valid) begin
      chk($sformatf("vec%0d result timeout", idx), 0, 1);
    end else begin
      chk($sformatf("vec%0d res_data", idx), res_data, v.exp_res);
      chk($sformatf("vec%0d res_id", idx), res_id, v.exp_id);
    end
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int ids[8];
    int ng;
    logic [15:0] ops_saved;

    rst_n = 1'b0;
    res_ready = 1'b0;
    drive_a(1, 1, 3, 2);
    drive_b(0, 0, 0, 0);

    // Reset values, with A already requesting.
    repeat (3) @(negedge clk);
    #2;
    chk("rst a_ready", a_ready, 0);
    chk("rst b_ready", b_ready, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst res_id", res_id, 0);
    chk("rst busy", busy, 0);
    chk("rst ops_done", ops_done, 0);
    chk("rst alu_sel", alu_sel, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);

    // Test 1: single A op, latency walk.
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    #2;
    chk("t1 c0 a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    #2;
    chk("t1 c1 alu_sel", alu_sel, 1);
    chk("t1 c1 alu_a", alu_a, 3);
    chk("t1 c1 alu_b", alu_b, 2);
    chk("t1 c1 busy", busy, 1);
    chk("t1 c1 res_valid", res_valid, 0);
    @(negedge clk); #2;
    chk("t1 c2 res_valid", res_valid, 1);
    chk("t1 c2 res_data", res_data, 5);
    chk("t1 c2 res_id", res_id, 0);
    @(negedge clk); #2;
    chk("t1 c3 ops_done", ops_done, 1);
    chk("t1 c3 busy", busy, 0);
    chk("t1 c3 res_valid", res_valid, 0);

    // Table-driven single operations (last grant before this is A).
    vecs[0] = '{1, 2, -8, -8, 1, 3, 7, 7, 1, 14};
    vecs[1] = '{1, 1, -8, -8, 1, 4, 1, 1, 0, -16};
    vecs[2] = '{0, 0, 0, 0, 1, 5, -1, -8, 1, -9};
    vecs[3] = '{1, 6, 7, -1, 0, 0, 0, 0, 0, 6};
    vecs[4] = '{1, 0, 5, 5, 1, 7, -3, -4, 1, -7};
    vecs[5] = '{1, 2, -4, 3, 1, 1, 0, 0, 0, -1};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Test 2: both requesters valid continuously; grants must alternate.
    @(negedge clk);
    res_ready = 1'b1;
    drive_a(1, 0, -8, -8);
    drive_b(1, 7, 7, 7);
    #2;
    ng = 0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      if (a_ready && b_ready) chk("t2 both ready", 1, 0);
      if (a_ready) begin ids[ng] = 0; ng++; end
      else if (b_ready) begin ids[ng] = 1; ng++; end
      if (ng < 8) begin @(negedge clk); #2; end
    end
    chk("t2 grant count", ng, 8);
    chk("t2 first grant", ids[0], 1);
    for (int k = 1; k < ng; k++) chk($sformatf("t2 grant%0d", k), ids[k], ids[0] ^ (k & 1));
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle();

    // Test 3: backpressure, request held across the handshake.
    @(negedge clk);
    res_ready = 1'b0;
    drive_a(1, 1, 2, 3);
    #2;
    wait_grant();
    @(negedge clk); #2;
    @(negedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      chk("t3 res_valid", res_valid, 1);
      chk("t3 res_data", res_data, 5);
      chk("t3 res_id", res_id, 0);
      chk("t3 alu_sel", alu_sel, 1);
      chk("t3 alu_a", alu_a, 2);
      chk("t3 alu_b", alu_b, 3);
      chk("t3 a_ready", a_ready, 0);
      @(negedge clk);
      if (i < 4) #2;
    end
    ops_saved = m_ops;
    res_ready = 1'b1;
    #2;
    chk("t3 hs a_ready", a_ready, 0);
    @(negedge clk); #2;
    chk("t3 after res_valid", res_valid, 0);
    chk("t3 after ops_done", ops_done, 32'(ops_saved + 16'd1));
    chk("t3 held req accepted", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle();

    // Test 6: B pulses valid only while the FSM is in EXEC.
    @(negedge clk);
    drive_a(1, 2, 1, 1);
    #2;
    wait_grant();
    @(negedge clk);
    a_valid = 1'b0;
    drive_b(1, 3, 2, 2);
    #2;
    chk("t6 b_ready in exec", b_ready, 0);
    @(negedge clk);
    b_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("t6 no spurious res", res_valid, 0);
      chk("t6 no spurious busy", busy, 0);
    end

    // Test 4: reset during EXEC, then the next tie goes to A.
    @(negedge clk);
    drive_a(1, 1, 1, 1);
    drive_b(1, 1, 2, 2);
    #2;
    wait_grant();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t4 res_valid", res_valid, 0);
    chk("t4 busy", busy, 0);
    chk("t4 alu_sel", alu_sel, 0);
    chk("t4 alu_a", alu_a, 0);
    chk("t4 alu_b", alu_b, 0);
    chk("t4 res_data", res_data, 0);
    chk("t4 ops_done", ops_done, 0);
    chk("t4 a_ready", a_ready, 0);
    chk("t4 b_ready", b_ready, 0);
    chk("t4 fsm_state", fsm_state, 0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1;
    #2;
    chk("t4 tie a_ready", a_ready, 1);
    chk("t4 tie b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle();
    chk("t4 ops after abort", ops_done, 1);

    // Test 5: counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.ops_done = 16'hFFFF;
    m_ops = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done;
    #2;
    chk("t5 preload", ops_done, 16'hFFFF);
    @(negedge clk);
    drive_a(1, 4, -2, 1);
    #2;
    wait_grant();
    @(negedge clk);
    a_valid = 1'b0;
    wait_idle();
    chk("t5 wrap", ops_done, 0);

    repeat (2) @(negedge clk);
    #3;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
